// File: rtl/count_mem_pkg.sv
// Shared constants and types for the counter sample buffer reader.
// Provides default sizes, derived pointer/level widths and the checker state.
package count_mem_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 16;
    localparam int CNT_W_DEF = 16;
    localparam int PTR_W_DEF = $clog2(DEPTH_DEF);
    localparam int LVL_W_DEF = PTR_W_DEF + 1;

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } chk_state_t;

endpackage

// File: rtl/count_mem_seq_check.sv
// Checks that popped samples form a +1 (mod 2^WIDTH) sequence.
// Also flags pops of the all-ones terminal count.
module count_mem_seq_check
    import count_mem_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_overrun,
    output logic             o_seq_err,
    output logic [CNT_W-1:0] o_seq_err_cnt,
    output logic             o_wrap
);

    chk_state_t       r_state;
    chk_state_t       w_state_next;
    logic [WIDTH-1:0] r_prev;
    logic             w_err;
    logic             r_seq_err;
    logic [CNT_W-1:0] r_seq_err_cnt;
    logic             r_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A dropped sample breaks continuity, so an overrun forces resync.
    always_comb begin
        w_state_next = r_state;
        w_err        = 1'b0;
        if (i_overrun) begin
            w_state_next = SYNC;
        end else if (i_pop) begin
            case (r_state)
                SYNC:  w_state_next = TRACK;
                TRACK: w_err = (i_data != r_prev + WIDTH'(1));
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev        <= '0;
            r_seq_err     <= 1'b0;
            r_seq_err_cnt <= '0;
            r_wrap        <= 1'b0;
        end else begin
            if (i_pop && !i_overrun) begin
                r_prev <= i_data;
            end
            r_seq_err <= w_err;
            if (w_err && (r_seq_err_cnt != '1)) begin
                r_seq_err_cnt <= r_seq_err_cnt + CNT_W'(1);
            end
            r_wrap <= i_pop && (i_data == '1);
        end
    end

    assign o_seq_err     = r_seq_err;
    assign o_seq_err_cnt = r_seq_err_cnt;
    assign o_wrap        = r_wrap;

endmodule

// File: rtl/count_mem_reader.sv
// Circular sample buffer drained through a valid/ready stream.
// The writer never stalls; when full, the oldest sample is overwritten.
module count_mem_reader
    import count_mem_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         rd_data,
    input  logic                     rd_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overrun,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     seq_err,
    output logic [CNT_W-1:0]         seq_err_cnt,
    output logic                     wrap
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_overrun;
    logic [CNT_W-1:0] r_drop_cnt;

    logic             w_pop;
    logic             w_full;
    logic             w_overrun;

    assign rd_valid  = (r_level != '0);
    assign rd_data   = r_mem[r_rd_ptr];
    assign w_pop     = rd_valid && rd_ready;
    assign w_full    = (r_level == LVL_W'(DEPTH));
    // A simultaneous pop frees the slot, so only an unpaired push into a full buffer drops.
    assign w_overrun = wr_en && !w_pop && w_full;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overrun  <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop || w_overrun) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (wr_en && !w_pop && !w_full) begin
                r_level <= r_level + LVL_W'(1);
            end else if (!wr_en && w_pop) begin
                r_level <= r_level - LVL_W'(1);
            end
            r_overrun <= w_overrun;
            if (w_overrun && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + CNT_W'(1);
            end
        end
    end

    assign level    = r_level;
    assign overrun  = r_overrun;
    assign drop_cnt = r_drop_cnt;

    count_mem_seq_check #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_seq_check (
        .clk           (clk),
        .rst           (rst),
        .i_pop         (w_pop),
        .i_data        (rd_data),
        .i_overrun     (w_overrun),
        .o_seq_err     (seq_err),
        .o_seq_err_cnt (seq_err_cnt),
        .o_wrap        (wrap)
    );

endmodule

// File: doc/count_mem_reader.md
# count_mem_reader

Read side of the counter sample buffer. The writer pushes one counter sample per `clk` edge into a 16-entry circular memory and never stalls. This block owns that memory and drains it through a valid/ready stream. It overwrites the oldest sample on overrun and checks that drained samples form a +1 (mod 2^WIDTH) sequence. It sits between the free-running counter and any consumer (socket/test harness) that reads samples back at its own pace.

## Interface
- `WIDTH`, 8: sample width in bits.
- `DEPTH`, 16: buffer entries; power of two, ≥2.
- `CNT_W`, 16: width of the drop and error counters.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_en`  in  1  writer pushes `wr_data` this cycle.
- `wr_data`  in  WIDTH  sample from counter.
- `rd_valid`  out  1  buffer non-empty; `rd_data` is the oldest sample.
- `rd_data`  out  WIDTH  head sample; don't-care when `rd_valid`=0.
- `rd_ready`  in  1  consumer accepts head this cycle.
- `level`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overrun`  out  1  one-cycle pulse: oldest sample was dropped.
- `drop_cnt`  out  CNT_W  total dropped samples, saturating.
- `seq_err`  out  1  one-cycle pulse: popped sample ≠ previous popped sample + 1.
- `seq_err_cnt`  out  CNT_W  total sequence errors, saturating.
- `wrap`  out  1  one-cycle pulse: popped sample was all-ones (counter end).

## Operation
- Storage: DEPTH×WIDTH array, `wr_ptr` and `rd_ptr` of $clog2(DEPTH) bits, both wrap naturally (DEPTH-1 → 0). `level` is tracked explicitly.
- Pop = `rd_valid && rd_ready`. Push = `wr_en`. Writes are never refused.
- Push, no pop, `level`<DEPTH: write at `wr_ptr`, `wr_ptr`++, `level`++.
- Push, no pop, `level`==DEPTH: overwrite at `wr_ptr`; `wr_ptr`++ and `rd_ptr`++; `level` unchanged. `overrun` pulses and `drop_cnt`++ (saturate at 2^CNT_W−1).
- Push and pop together: both pointers advance and `level` is unchanged. This is never an overrun, even when full.
- Pop while empty cannot occur (`rd_valid`=0). Push at `level`=0 with `rd_ready`=1 is a push only.
- Sequence checker FSM, states:
  - SYNC: no reference value held. On a pop, store `rd_data` as `prev` and go to TRACK. No check is made.
  - TRACK: on a pop, compare `rd_data` with `prev`+1 mod 2^WIDTH. On mismatch, `seq_err` pulses and `seq_err_cnt`++ (saturating). Then `prev` ← `rd_data` and the FSM stays in TRACK.
  - TRACK → SYNC on an overrun cycle. If a pop coincides with the overrun, the popped value is not checked.
- `wrap` pulses for every pop whose `rd_data` is all-ones. It is independent of the FSM.

## Timing
- Reset values: `rd_valid` 0, `level` 0, `overrun` 0, `drop_cnt` 0, `seq_err` 0, `seq_err_cnt` 0, `wrap` 0. `rd_data` is don't-care. Pointers are 0 and the FSM is in SYNC. Memory contents are not reset.
- Reset asserted mid-operation discards all buffered data immediately (asynchronously); no pulse outputs fire.
- `rd_data` is a combinational read of `mem[rd_ptr]`. A sample pushed at edge N is visible on `rd_valid`/`rd_data` after edge N (latency 1 edge).
- `overrun`, `seq_err` and `wrap` are registered. Each is high for exactly the cycle following the triggering edge.
- Counters update on the same edge that registers the corresponding pulse.

## Structure
- Package `count_mem_pkg` holds the default WIDTH/DEPTH/CNT_W constants, the derived pointer and level widths, and the checker state enum (SYNC, TRACK).
- Sub-module `count_mem_seq_check`: the FSM, `prev` register, `seq_err`/`seq_err_cnt`, and `wrap`. Its inputs are the pop strobe, `rd_data` and the overrun strobe. The buffer and pointer logic stay in the top module.

## Test plan
- Reset, then push 0..4 with `rd_ready`=0 → `level`=5 and `rd_data`=0. Then hold `rd_ready`=1 → pops 0,1,2,3,4, `level` back to 0, no `seq_err`.
- Push 0..19 with `rd_ready`=0 → `level`=16, `overrun` pulses 4 times, `drop_cnt`=4. Drain → reads 4..19 with no `seq_err`.
- Full buffer, simultaneous push and pop for 10 cycles → `level` stays 16, `drop_cnt` unchanged, data in order.
- Stream with a gap (push 10,11,13) while draining → one `seq_err` on 13, `seq_err_cnt`=1.
- Push 250..255,0,1 while draining → `wrap` pulses once on 255, no `seq_err` across 255→0.
- Assert `rst` asynchronously with `level`=7 and `drop_cnt`=3 → all outputs 0 before the next `clk` edge. The next push 42 reads back 42 with no `seq_err` (FSM in SYNC).
